// File: rtl/vanilla_longop_scoreboard_if.sv
//------------------------------------------------------------------------------
// Module  : vanilla_longop_scoreboard_if
// Brief   : Decode/writeback/status bundle for the long-op issue scoreboard.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface vanilla_longop_scoreboard_if #(
  parameter int max_out_p = 16
);
  localparam int cnt_width_lp = $clog2(max_out_p + 1);

  logic                    id_v_i;
  logic [4:0]              id_rs1_i;
  logic [4:0]              id_rs2_i;
  logic [4:0]              id_rs3_i;
  logic [4:0]              id_rd_i;
  logic                    read_rs1_i;
  logic                    read_rs2_i;
  logic                    read_frs1_i;
  logic                    read_frs2_i;
  logic                    read_frs3_i;
  logic                    write_rd_i;
  logic                    write_frd_i;
  logic                    is_remote_i;
  logic                    is_idiv_i;
  logic                    is_fdiv_i;
  logic                    int_clr_v_i;
  logic [4:0]              int_clr_id_i;
  logic                    fp_clr_v_i;
  logic [4:0]              fp_clr_id_i;
  logic                    remote_done_i;
  logic                    idiv_done_i;
  logic                    fdiv_done_i;
  logic                    stall_o;
  logic [31:0]             int_sb_o;
  logic [31:0]             fp_sb_o;
  logic [cnt_width_lp-1:0] out_cnt_o;
  logic                    err_o;

  modport master (
    output id_v_i, id_rs1_i, id_rs2_i, id_rs3_i, id_rd_i,
           read_rs1_i, read_rs2_i, read_frs1_i, read_frs2_i, read_frs3_i,
           write_rd_i, write_frd_i, is_remote_i, is_idiv_i, is_fdiv_i,
           int_clr_v_i, int_clr_id_i, fp_clr_v_i, fp_clr_id_i,
           remote_done_i, idiv_done_i, fdiv_done_i,
    input  stall_o, int_sb_o, fp_sb_o, out_cnt_o, err_o
  );

  modport slave (
    input  id_v_i, id_rs1_i, id_rs2_i, id_rs3_i, id_rd_i,
           read_rs1_i, read_rs2_i, read_frs1_i, read_frs2_i, read_frs3_i,
           write_rd_i, write_frd_i, is_remote_i, is_idiv_i, is_fdiv_i,
           int_clr_v_i, int_clr_id_i, fp_clr_v_i, fp_clr_id_i,
           remote_done_i, idiv_done_i, fdiv_done_i,
    output stall_o, int_sb_o, fp_sb_o, out_cnt_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/vanilla_longop_scoreboard.sv
//------------------------------------------------------------------------------
// Module  : vanilla_longop_scoreboard
// Brief   : Gates decode->execute issue on pending long-latency destinations,
//           busy divide units and remote-op credits.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vanilla_longop_scoreboard #(
  parameter int max_out_p = 16
) (
  input  wire                              clk_i,
  input  wire                              reset_n_i,
  vanilla_longop_scoreboard_if.slave       sb_if
);
  localparam int cnt_width_lp = $clog2(max_out_p + 1);
  localparam logic [cnt_width_lp-1:0] c_max_cnt = cnt_width_lp'(max_out_p);
  localparam logic [cnt_width_lp-1:0] c_one     = cnt_width_lp'(1);

  logic [31:0]             r_int_sb, r_fp_sb;
  logic [cnt_width_lp-1:0] r_out_cnt;
  logic                    r_idiv_busy, r_fdiv_busy, r_err;

  logic [31:0]             w_int_clr_mask, w_fp_clr_mask;
  logic [31:0]             w_eff_int, w_eff_fp;
  logic [31:0]             w_int_set_mask, w_fp_set_mask;
  logic                    w_raw, w_waw, w_idiv_stall, w_fdiv_stall, w_cred_stall;
  logic                    w_stall, w_issue, w_is_long, w_int_dst;
  logic                    w_inc, w_dec, w_err_evt;
  logic [cnt_width_lp-1:0] w_out_cnt_n;

  always_comb begin
    w_int_clr_mask = sb_if.int_clr_v_i ? (32'd1 << sb_if.int_clr_id_i) : 32'd0;
    w_fp_clr_mask  = sb_if.fp_clr_v_i  ? (32'd1 << sb_if.fp_clr_id_i)  : 32'd0;
    // Writebacks bypass into the hazard check so dependents issue in the clear cycle.
    w_eff_int = r_int_sb & ~w_int_clr_mask;
    w_eff_fp  = r_fp_sb  & ~w_fp_clr_mask;

    w_raw = (sb_if.read_rs1_i  & w_eff_int[sb_if.id_rs1_i])
          | (sb_if.read_rs2_i  & w_eff_int[sb_if.id_rs2_i])
          | (sb_if.read_frs1_i & w_eff_fp[sb_if.id_rs1_i])
          | (sb_if.read_frs2_i & w_eff_fp[sb_if.id_rs2_i])
          | (sb_if.read_frs3_i & w_eff_fp[sb_if.id_rs3_i]);
    w_waw = (sb_if.write_rd_i  & w_eff_int[sb_if.id_rd_i])
          | (sb_if.write_frd_i & w_eff_fp[sb_if.id_rd_i]);

    w_idiv_stall = sb_if.is_idiv_i & r_idiv_busy & ~sb_if.idiv_done_i;
    w_fdiv_stall = sb_if.is_fdiv_i & r_fdiv_busy & ~sb_if.fdiv_done_i;
    w_cred_stall = sb_if.is_remote_i & (r_out_cnt == c_max_cnt);

    w_stall = sb_if.id_v_i & (w_raw | w_waw | w_idiv_stall | w_fdiv_stall | w_cred_stall);
    w_issue = sb_if.id_v_i & ~w_stall;

    w_is_long = sb_if.is_remote_i | sb_if.is_idiv_i | sb_if.is_fdiv_i;
    w_int_dst = sb_if.write_rd_i & (sb_if.id_rd_i != 5'd0);
    w_int_set_mask = (w_issue & w_is_long & w_int_dst)
                   ? (32'd1 << sb_if.id_rd_i) : 32'd0;
    w_fp_set_mask  = (w_issue & w_is_long & ~w_int_dst & sb_if.write_frd_i)
                   ? (32'd1 << sb_if.id_rd_i) : 32'd0;

    w_inc = w_issue & sb_if.is_remote_i;
    w_dec = sb_if.remote_done_i & (r_out_cnt != '0);
    w_out_cnt_n = r_out_cnt;
    if (w_inc && !w_dec) begin
      w_out_cnt_n = r_out_cnt + c_one;
    end else if (!w_inc && w_dec) begin
      w_out_cnt_n = r_out_cnt - c_one;
    end

    w_err_evt = (sb_if.int_clr_v_i & ~r_int_sb[sb_if.int_clr_id_i])
              | (sb_if.fp_clr_v_i  & ~r_fp_sb[sb_if.fp_clr_id_i])
              | (sb_if.remote_done_i & (r_out_cnt == '0))
              | (sb_if.idiv_done_i & ~r_idiv_busy)
              | (sb_if.fdiv_done_i & ~r_fdiv_busy);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_int_sb    <= 32'd0;
      r_fp_sb     <= 32'd0;
      r_out_cnt   <= '0;
      r_idiv_busy <= 1'b0;
      r_fdiv_busy <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Issue sets are OR-ed after clears so a same-register set wins.
      r_int_sb    <= (r_int_sb & ~w_int_clr_mask) | w_int_set_mask;
      r_fp_sb     <= (r_fp_sb  & ~w_fp_clr_mask)  | w_fp_set_mask;
      r_out_cnt   <= w_out_cnt_n;
      r_idiv_busy <= (w_issue & sb_if.is_idiv_i) ? 1'b1
                   : (sb_if.idiv_done_i ? 1'b0 : r_idiv_busy);
      r_fdiv_busy <= (w_issue & sb_if.is_fdiv_i) ? 1'b1
                   : (sb_if.fdiv_done_i ? 1'b0 : r_fdiv_busy);
      r_err       <= r_err | w_err_evt;
    end
  end

  assign sb_if.stall_o   = w_stall;
  assign sb_if.int_sb_o  = r_int_sb;
  assign sb_if.fp_sb_o   = r_fp_sb;
  assign sb_if.out_cnt_o = r_out_cnt;
  assign sb_if.err_o     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_vanilla_longop_scoreboard.sv
//------------------------------------------------------------------------------
// Module  : tb_vanilla_longop_scoreboard
// Brief   : Directed self-checking bench for vanilla_longop_scoreboard.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_vanilla_longop_scoreboard;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  vanilla_longop_scoreboard_if #(.max_out_p(16)) sb_if ();

  vanilla_longop_scoreboard #(.max_out_p(16)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .sb_if     (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sb_if.id_v_i = 0; sb_if.id_rs1_i = 0; sb_if.id_rs2_i = 0; sb_if.id_rs3_i = 0;
    sb_if.id_rd_i = 0; sb_if.read_rs1_i = 0; sb_if.read_rs2_i = 0;
    sb_if.read_frs1_i = 0; sb_if.read_frs2_i = 0; sb_if.read_frs3_i = 0;
    sb_if.write_rd_i = 0; sb_if.write_frd_i = 0; sb_if.is_remote_i = 0;
    sb_if.is_idiv_i = 0; sb_if.is_fdiv_i = 0; sb_if.int_clr_v_i = 0;
    sb_if.int_clr_id_i = 0; sb_if.fp_clr_v_i = 0; sb_if.fp_clr_id_i = 0;
    sb_if.remote_done_i = 0; sb_if.idiv_done_i = 0; sb_if.fdiv_done_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    #12;
    reset_n = 1;
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n = 0;
    idle_inputs();
    #12;
    // Reset state, plus a hazard-free instruction presented during reset.
    sb_if.id_v_i = 1; sb_if.read_rs1_i = 1; sb_if.id_rs1_i = 2;
    #1;
    chk("rst_int_sb", sb_if.int_sb_o, 0);
    chk("rst_fp_sb", sb_if.fp_sb_o, 0);
    chk("rst_cnt", 32'(sb_if.out_cnt_o), 0);
    chk("rst_err", 32'(sb_if.err_o), 0);
    chk("rst_stall", 32'(sb_if.stall_o), 0);
    idle_inputs();
    reset_n = 1;
    step();

    // Remote lw x5
    sb_if.id_v_i = 1; sb_if.is_remote_i = 1; sb_if.write_rd_i = 1; sb_if.id_rd_i = 5;
    sb_if.read_rs1_i = 1; sb_if.id_rs1_i = 1;
    #1; chk("lw_stall", 32'(sb_if.stall_o), 0);
    step();
    chk("lw_int_sb", sb_if.int_sb_o, 32'h20);
    chk("lw_cnt", 32'(sb_if.out_cnt_o), 1);
    // add x6,x5,x1
    idle_inputs();
    sb_if.id_v_i = 1; sb_if.read_rs1_i = 1; sb_if.id_rs1_i = 5; sb_if.read_rs2_i = 1;
    sb_if.id_rs2_i = 1; sb_if.write_rd_i = 1; sb_if.id_rd_i = 6;
    #1; chk("raw_stall", 32'(sb_if.stall_o), 1);
    step();
    chk("raw_stall_hold", 32'(sb_if.stall_o), 1);
    chk("raw_int_sb_hold", sb_if.int_sb_o, 32'h20);
    sb_if.int_clr_v_i = 1; sb_if.int_clr_id_i = 5; sb_if.remote_done_i = 1;
    #1; chk("clr_bypass_stall", 32'(sb_if.stall_o), 0);
    step();
    chk("clr_int_sb", sb_if.int_sb_o, 0);
    chk("clr_cnt", 32'(sb_if.out_cnt_o), 0);
    chk("clr_err", 32'(sb_if.err_o), 0);

    // Remote load to x0, then a read of x0 that also retires it
    idle_inputs();
    sb_if.id_v_i = 1; sb_if.is_remote_i = 1; sb_if.write_rd_i = 1; sb_if.id_rd_i = 0;
    #1; chk("x0_ld_stall", 32'(sb_if.stall_o), 0);
    step();
    chk("x0_int_sb", sb_if.int_sb_o, 0);
    chk("x0_cnt", 32'(sb_if.out_cnt_o), 1);
    idle_inputs();
    sb_if.id_v_i = 1; sb_if.read_rs1_i = 1; sb_if.id_rs1_i = 0; sb_if.remote_done_i = 1;
    #1; chk("x0_read_stall", 32'(sb_if.stall_o), 0);
    step();
    chk("x0_cnt_ret", 32'(sb_if.out_cnt_o), 0);

    // Credit limit: 16 remote loads to x1..x16
    idle_inputs();
    sb_if.id_v_i = 1; sb_if.is_remote_i = 1; sb_if.write_rd_i = 1;
    for (int i = 1; i <= 16; i++) begin
      sb_if.id_rd_i = 5'(i);
      #1; chk("cred_fill_stall", 32'(sb_if.stall_o), 0);
      step();
    end
    chk("cred_full_cnt", 32'(sb_if.out_cnt_o), 16);
    chk("cred_full_sb", sb_if.int_sb_o, 32'h0001_FFFE);
    sb_if.id_rd_i = 20;
    #1; chk("cred_17_stall", 32'(sb_if.stall_o), 1);
    sb_if.remote_done_i = 1;
    #1; chk("cred_done_no_bypass", 32'(sb_if.stall_o), 1);
    step();
    chk("cred_cnt_15", 32'(sb_if.out_cnt_o), 15);
    chk("cred_sb_hold", sb_if.int_sb_o, 32'h0001_FFFE);
    sb_if.remote_done_i = 0;
    #1; chk("cred_17_go", 32'(sb_if.stall_o), 0);
    step();
    chk("cred_cnt_16", 32'(sb_if.out_cnt_o), 16);
    chk("cred_sb_20", sb_if.int_sb_o, 32'h0011_FFFE);
    // Issue and retire together leaves the count unchanged
    sb_if.id_v_i = 0; sb_if.remote_done_i = 1;
    step();
    sb_if.id_v_i = 1; sb_if.id_rd_i = 21;
    #1; chk("cred_both_stall", 32'(sb_if.stall_o), 0);
    step();
    chk("cred_both_cnt", 32'(sb_if.out_cnt_o), 15);
    chk("cred_err", 32'(sb_if.err_o), 0);

    do_reset();
    chk("rst2_int_sb", sb_if.int_sb_o, 0);
    chk("rst2_cnt", 32'(sb_if.out_cnt_o), 0);

    // fdiv f3 = f1/f2, then another fdiv to f3
    sb_if.id_v_i = 1; sb_if.is_fdiv_i = 1; sb_if.write_frd_i = 1; sb_if.id_rd_i = 3;
    sb_if.read_frs1_i = 1; sb_if.id_rs1_i = 1; sb_if.read_frs2_i = 1; sb_if.id_rs2_i = 2;
    #1; chk("fdiv1_stall", 32'(sb_if.stall_o), 0);
    step();
    chk("fdiv1_fp_sb", sb_if.fp_sb_o, 32'h8);
    sb_if.id_rs1_i = 5; sb_if.id_rs2_i = 6;
    #1; chk("fdiv2_stall", 32'(sb_if.stall_o), 1);
    step();
    chk("fdiv2_stall_hold", 32'(sb_if.stall_o), 1);
    sb_if.fdiv_done_i = 1; sb_if.fp_clr_v_i = 1; sb_if.fp_clr_id_i = 3;
    #1; chk("fdiv2_done_go", 32'(sb_if.stall_o), 0);
    step();
    chk("fdiv2_fp_sb", sb_if.fp_sb_o, 32'h8);
    chk("fdiv2_err", 32'(sb_if.err_o), 0);
    // Unit is busy again: an fdiv to a free register still stalls
    sb_if.fdiv_done_i = 0; sb_if.fp_clr_v_i = 0; sb_if.id_rd_i = 7;
    #1; chk("fdiv3_busy_stall", 32'(sb_if.stall_o), 1);
    idle_inputs();
    sb_if.fdiv_done_i = 1; sb_if.fp_clr_v_i = 1; sb_if.fp_clr_id_i = 3;
    step();
    chk("fdiv_drain_sb", sb_if.fp_sb_o, 0);
    chk("fdiv_drain_err", 32'(sb_if.err_o), 0);

    // idiv x9, then idiv x10 issues in the done cycle
    idle_inputs();
    sb_if.id_v_i = 1; sb_if.is_idiv_i = 1; sb_if.write_rd_i = 1; sb_if.id_rd_i = 9;
    step();
    chk("idiv1_sb", sb_if.int_sb_o, 32'h200);
    sb_if.id_rd_i = 10;
    #1; chk("idiv2_stall", 32'(sb_if.stall_o), 1);
    sb_if.idiv_done_i = 1;
    #1; chk("idiv2_done_go", 32'(sb_if.stall_o), 0);
    step();
    chk("idiv2_sb", sb_if.int_sb_o, 32'h600);

    // Clear of an idle bit raises a sticky error
    idle_inputs();
    sb_if.int_clr_v_i = 1; sb_if.int_clr_id_i = 7;
    step();
    chk("err_set", 32'(sb_if.err_o), 1);
    idle_inputs();
    step(); step();
    chk("err_sticky", 32'(sb_if.err_o), 1);

    // Async reset with int_sb=0x20 and out_cnt=3
    do_reset();
    chk("err_cleared", 32'(sb_if.err_o), 0);
    sb_if.id_v_i = 1; sb_if.is_remote_i = 1; sb_if.write_rd_i = 1; sb_if.id_rd_i = 5;
    step();
    sb_if.id_rd_i = 0;
    step(); step();
    chk("pre_rst_sb", sb_if.int_sb_o, 32'h20);
    chk("pre_rst_cnt", 32'(sb_if.out_cnt_o), 3);
    idle_inputs();
    sb_if.id_v_i = 1; sb_if.read_rs1_i = 1; sb_if.id_rs1_i = 5;
    #2;
    reset_n = 0;
    #1;
    chk("async_rst_sb", sb_if.int_sb_o, 0);
    chk("async_rst_cnt", 32'(sb_if.out_cnt_o), 0);
    chk("async_rst_stall", 32'(sb_if.stall_o), 0);
    #10;
    reset_n = 1;
    idle_inputs();
    // Late writebacks after reset are protocol errors
    sb_if.int_clr_v_i = 1; sb_if.int_clr_id_i = 5;
    step();
    chk("late_wb_err", 32'(sb_if.err_o), 1);
    do_reset();
    sb_if.remote_done_i = 1;
    step();
    chk("done_at_zero_cnt", 32'(sb_if.out_cnt_o), 0);
    chk("done_at_zero_err", 32'(sb_if.err_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vanilla_longop_scoreboard.md
Name: vanilla_longop_scoreboard

Overview:
- Issue-gating controller between the vanilla decode stage and the execute stage.
- Tracks destination registers of long-latency ops in flight: remote loads/AMOs, idiv, fdiv/fsqrt. Keeps one pending bit per integer and per FP register, plus a count of outstanding remote ops.
- Stalls an issuing instruction on RAW or WAW hazards, on a busy single-instance unit (idiv, fdiv/fsqrt), or when the remote-op credit limit is reached.

Parameters:
- max_out_p, 16, maximum outstanding remote loads/AMOs.
- cnt_width_lp, $clog2(max_out_p+1), width of the outstanding counter.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- id_v_i  in  1  decode stage holds a valid instruction
- id_rs1_i, id_rs2_i, id_rs3_i  in  5 each  source register ids
- id_rd_i  in  5  destination register id
- read_rs1_i, read_rs2_i  in  1 each  integer source reads (from decode_s)
- read_frs1_i, read_frs2_i, read_frs3_i  in  1 each  FP source reads
- write_rd_i, write_frd_i  in  1 each  integer / FP destination write
- is_remote_i  in  1  remote load/AMO; scoreboards rd (int or FP) and consumes a credit
- is_idiv_i  in  1  idiv op
- is_fdiv_i  in  1  fdiv/fsqrt op
- int_clr_v_i, int_clr_id_i  in  1, 5  integer long-op writeback
- fp_clr_v_i, fp_clr_id_i  in  1, 5  FP long-op writeback
- remote_done_i  in  1  one remote op retired (returns a credit)
- idiv_done_i, fdiv_done_i  in  1 each  unit completion
- stall_o  out  1  issue blocked this cycle (combinational)
- int_sb_o, fp_sb_o  out  32 each  registered pending bitmaps
- out_cnt_o  out  cnt_width_lp  outstanding remote ops
- err_o  out  1  sticky protocol error

Behaviour:
- Reset is asynchronous on falling reset_n_i. On reset:
  - int_sb_o=0, fp_sb_o=0, out_cnt_o=0.
  - idiv_busy=0, fdiv_busy=0, err_o=0.
  - stall_o reflects the reset state, so it is 0 for a hazard-free instruction.
- Effective pending bits, used by the hazard check:
  - eff_int = int_sb & ~(int_clr_v_i ? onehot(int_clr_id_i) : 0); same form for FP.
  - A writeback therefore unblocks a dependent instruction in the same cycle.
- Hazard terms:
  - raw = (read_rs1_i & eff_int[rs1]) | (read_rs2_i & eff_int[rs2]) | (read_frsN_i & eff_fp[rsN]) for N=1..3.
  - waw = (write_rd_i & eff_int[rd]) | (write_frd_i & eff_fp[rd]).
  - Integer reg 0 never hazards and is never scoreboarded.
- Structural terms:
  - idiv_stall = is_idiv_i & idiv_busy & ~idiv_done_i.
  - fdiv_stall = is_fdiv_i & fdiv_busy & ~fdiv_done_i.
  - cred_stall = is_remote_i & (out_cnt == max_out_p), with no bypass from remote_done_i.
- stall_o = id_v_i & (raw | waw | idiv_stall | fdiv_stall | cred_stall).
- issue = id_v_i & ~stall_o. Issue is the only event that sets state.
- Scoreboard update each cycle, in this order:
  1. Apply clears.
  2. Apply issue sets, which win over clears.
  - Issue with (is_remote_i | is_idiv_i | is_fdiv_i) sets int_sb[rd] if write_rd_i and rd≠0, else sets fp_sb[rd] if write_frd_i.
  - A same-register set and clear in one cycle leaves the bit at 1.
- Busy flags:
  - idiv_busy next = issue&is_idiv_i ? 1 : (idiv_done_i ? 0 : idiv_busy). fdiv_busy follows the same rule.
- Counter:
  - Increments on issue&is_remote_i and decrements on remote_done_i; both in one cycle leaves it unchanged.
  - It never wraps. remote_done_i with count 0 holds at 0 and sets err_o.
- err_o is sticky until reset. It sets on:
  - a clear of a bit that is already 0;
  - remote_done_i with count 0;
  - a done pulse while the unit is not busy.
- Reset mid-operation drops all pending state. Late writebacks after reset are then flagged as errors.
- Latency: stall_o is combinational in the same cycle. Set and clear effects appear on the *_sb_o outputs next cycle.

Test Plan:
- Remote lw x5 issued, then add x6,x5,x1 → stall_o=1 until int_clr (id 5). In the clear cycle stall_o=0 and the add issues; int_sb_o[5]=0 next cycle.
- Write to x0 from a remote load → no scoreboard bit set; a following read of x0 does not stall.
- Issue 16 remote loads with no done → out_cnt_o=16; the 17th stalls. With remote_done_i and issue in the same cycle → stall_o=1 and out_cnt_o goes 16→15.
- fdiv f3 issued, second fdiv presented → stalls. In the fdiv_done_i cycle with fp_clr (id 3) → the second fdiv issues; fp_sb_o[3]=1 and fdiv_busy=1 next cycle.
- Clear of int reg 7 with int_sb_o[7]=0 → err_o=1 and stays 1 until reset_n_i=0.
- With int_sb_o=0x20 and out_cnt=3, drop reset_n_i asynchronously mid-cycle → all outputs 0 immediately, before the next clock edge.
